// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one burst memory port between the I-cache and D-cache miss paths.
// Each granted request moves a whole cache line as BEATS consecutive memory beats.
module mem_port_arbiter #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [31:0]       i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFFS_W = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;

  state_e             state_q, state_d;
  logic               gnt_q;
  logic               last_q;
  logic [31:0]        addr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [LINE_W-1:0]  line_q;
  logic [LINE_W-1:0]  i_hold_q;
  logic [LINE_W-1:0]  d_hold_q;

  logic i_req, d_req, grant_d, last_beat;

  // gnt_q/last_q encode the requester: 0 = I side, 1 = D side.
  assign i_req     = i_read;
  assign d_req     = d_read | d_write;
  assign grant_d   = d_req & (~i_req | ~last_q);
  assign last_beat = mem_resp & (cnt_q == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req)
          state_d = (grant_d && d_write) ? WR_BURST : RD_BURST;
      end
      RD_BURST, WR_BURST: begin
        if (last_beat) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-side hold registers keep each requester's last line visible between completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      addr_q   <= '0;
      cnt_q    <= '0;
      line_q   <= '0;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            gnt_q  <= grant_d;
            addr_q <= grant_d ? {d_addr[31:OFFS_W], OFFS_W'(0)}
                              : {i_addr[31:OFFS_W], OFFS_W'(0)};
            cnt_q  <= '0;
            if (grant_d && d_write) line_q <= d_wdata;
          end
        end
        RD_BURST: begin
          if (mem_resp) begin
            line_q[BEAT_W*cnt_q +: BEAT_W] <= mem_rdata;
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        WR_BURST: begin
          if (mem_resp) cnt_q <= cnt_q + CNT_W'(1);
        end
        DONE: begin
          last_q <= gnt_q;
          if (gnt_q) d_hold_q <= line_q;
          else       i_hold_q <= line_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mem_read    = (state_q == RD_BURST);
    mem_write   = (state_q == WR_BURST);
    mem_address = addr_q;
    mem_wdata   = '0;
    if (state_q == WR_BURST) mem_wdata = line_q[BEAT_W*cnt_q +: BEAT_W];
    i_resp  = (state_q == DONE) && !gnt_q;
    d_resp  = (state_q == DONE) &&  gnt_q;
    i_rdata = i_resp ? line_q : i_hold_q;
    d_rdata = d_resp ? line_q : d_hold_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected transactions, a monitor
// checks the memory-side burst and each requester completion against them.
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read, d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           sideD;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  txn_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   monBeats = 0;
  int   memGap = 0;

  // Memory returns table A, or table B when address bit 10 is set, so lines are distinguishable.
  logic [63:0]  beatsA[4] = '{64'h1111111111111111, 64'h2222222222222222,
                              64'h3333333333333333, 64'h4444444444444444};
  logic [63:0]  beatsB[4] = '{64'h5555555555555555, 64'h6666666666666666,
                              64'h7777777777777777, 64'h8888888888888888};
  localparam logic [255:0] LINE_A = {64'h4444444444444444, 64'h3333333333333333,
                                     64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] LINE_B = {64'h8888888888888888, 64'h7777777777777777,
                                     64'h6666666666666666, 64'h5555555555555555};
  localparam logic [255:0] WLINE  = 256'h0123456789ABCDEF_FEDCBA9876543210_0F0F0F0F0F0F0F0F_11223344DDCCBBAA;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input bit sideD, input bit wr, input logic [31:0] a, input logic [255:0] data);
    txn_t t;
    t.sideD = sideD; t.wr = wr; t.addr = a; t.data = data;
    expQ.push_back(t);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_i_rdata"}, i_rdata, '0);
    checkOutput({tag, "_d_rdata"}, d_rdata, '0);
    checkOutput({tag, "_ctrl"}, {mem_read, mem_write, i_resp, d_resp, mem_address, mem_wdata}, '0);
  endtask

  // Drives one request, holds it until the matching resp, then drops it after the next edge.
  task automatic applyStimulus(input bit sideD, input bit wr, input logic [31:0] a,
                               input logic [255:0] wdata);
    bit got = 1'b0;
    if (sideD) begin
      d_addr = a; d_wdata = wdata; d_read = !wr; d_write = wr;
    end else begin
      i_addr = a; i_read = 1'b1;
    end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (sideD ? d_resp : i_resp) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput(sideD ? "d_resp_timeout" : "i_resp_timeout", got, 1'b1);
    @(posedge clk); #1;
    if (sideD) begin
      d_read = 1'b0; d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // Memory model: one beat per cycle, or one beat every memGap+1 cycles.
  initial begin
    int mbeat;
    int gapCnt;
    mbeat = 0; gapCnt = 0;
    mem_resp = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_resp = 1'b0;
      if (!rst_n || !(mem_read || mem_write)) begin
        mbeat = 0; gapCnt = 0;
      end else if (gapCnt < memGap) begin
        gapCnt++;
      end else begin
        gapCnt = 0;
        mem_resp = 1'b1;
        mem_rdata = mem_address[10] ? beatsB[mbeat % 4] : beatsA[mbeat % 4];
        mbeat++;
      end
    end
  end

  // Monitor: checks command/address every busy cycle, write beats on each mem_resp,
  // and the completion side, beat count and returned line on each resp pulse.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        monBeats = 0;
      end else begin
        if (mem_read || mem_write) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_cmd", {mem_read, mem_write}, 2'b00);
          end else begin
            t = expQ[0];
            checkOutput("cmd_addr", {mem_read, mem_write, mem_address},
                        {!t.wr, t.wr, t.addr[31:5], 5'b0});
            if (mem_resp) begin
              if (mem_write) begin
                if (monBeats < 4) checkOutput("mem_wdata", mem_wdata, t.data[64*monBeats +: 64]);
                else checkOutput("extra_wbeat", monBeats, 3);
              end
              monBeats++;
            end
          end
        end
        if (i_resp || d_resp) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_resp", {i_resp, d_resp}, 2'b00);
          end else begin
            t = expQ.pop_front();
            checkOutput("resp_side", {i_resp, d_resp}, t.sideD ? 2'b01 : 2'b10);
            checkOutput("beat_count", monBeats, 4);
            if (!t.wr) checkOutput(t.sideD ? "d_rdata" : "i_rdata",
                                   t.sideD ? d_rdata : i_rdata, t.data);
          end
          monBeats = 0;
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    #1 checkAllZero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkAllZero("post_reset");

    // Simultaneous requests right after reset: I wins the first tie.
    pushExp(1'b0, 1'b0, 32'h0000_0100, LINE_A);
    pushExp(1'b1, 1'b1, 32'h0000_0200, WLINE);
    fork
      applyStimulus(1'b0, 1'b0, 32'h0000_0100, '0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0200, WLINE);
    join

    // Single I read of an unaligned address.
    pushExp(1'b0, 1'b0, 32'h0000_0064, LINE_A);
    applyStimulus(1'b0, 1'b0, 32'h0000_0064, '0);

    // I was granted last, so D wins this tie.
    pushExp(1'b1, 1'b0, 32'h0000_0400, LINE_B);
    pushExp(1'b0, 1'b0, 32'h0000_0300, LINE_A);
    fork
      applyStimulus(1'b0, 1'b0, 32'h0000_0300, '0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0400, '0);
    join
    checkOutput("hold_d_rdata", d_rdata, LINE_B);

    // D write beats go out low slice first.
    pushExp(1'b1, 1'b1, 32'h8000_0020, WLINE);
    applyStimulus(1'b1, 1'b1, 32'h8000_0020, WLINE);
    checkOutput("hold_i_rdata", i_rdata, LINE_A);

    // Stalled burst: three idle cycles between beats.
    memGap = 3;
    pushExp(1'b0, 1'b0, 32'h8000_1240, LINE_A);
    applyStimulus(1'b0, 1'b0, 32'h8000_1240, '0);
    memGap = 0;

    // Reset in the middle of a D read; the held request restarts from beat 0.
    pushExp(1'b1, 1'b0, 32'h0000_0400, LINE_B);
    fork
      applyStimulus(1'b1, 1'b0, 32'h0000_0400, '0);
      begin
        for (int k = 0; k < 50; k++) begin
          @(negedge clk); #1;
          if (monBeats >= 2) break;
        end
        checkOutput("beats_before_reset", monBeats, 2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1 checkAllZero("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join

    // Back-to-back I reads: request stays high across the completion.
    pushExp(1'b0, 1'b0, 32'h0000_0040, LINE_A);
    pushExp(1'b0, 1'b0, 32'h0000_0440, LINE_B);
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, '0);
    fork
      applyStimulus(1'b0, 1'b0, 32'h0000_0440, '0);
      begin
        n = 0;
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          n++;
          if (mem_read) break;
        end
        checkOutput("b2b_restart_gap", n, 2);
      end
    join

    for (int k = 0; k < 50 && expQ.size() != 0; k++) @(negedge clk);
    checkOutput("queue_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
